canny_gauss3x3: RTL and testbench
=================================

# canny_gauss3x3

Streaming 3×3 Gaussian smoothing stage at the front of the Canny edge-detection model.
- Input: raster-order grey pixels.
- Storage: two internal line stores hold the previous two rows; a 3×3 window register is built from them.
- Output: one smoothed pixel per accepted input pixel, after a fixed latency.
- Downstream: the output stream feeds the gradient (Sobel) stage.

## Interface
- DATA_WIDTH, 8: pixel bit width, input and output.
- IMG_WIDTH, 640: pixels per line; also the depth of each line store.
- IMG_HEIGHT, 480: lines per frame.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pix_vld  in  1  input pixel valid; one pixel accepted per cycle when high. No backpressure.
- pix_sof  in  1  start of frame; qualified by pix_vld; marks pixel (0,0).
- pix_data  in  DATA_WIDTH  input pixel.
- out_vld  out  1  output pixel valid.
- out_sof  out  1  output corresponds to input (0,0).
- out_eol  out  1  output corresponds to input column IMG_WIDTH-1.
- out_eof  out  1  output corresponds to input (IMG_HEIGHT-1, IMG_WIDTH-1).
- out_data  out  DATA_WIDTH  smoothed pixel.

## Operation

**Position counters**
- col in 0..IMG_WIDTH-1; row in 0..IMG_HEIGHT-1.
- Each accepted pixel gets position (row, col); col then increments.
- At col = IMG_WIDTH-1: col wraps to 0 and row increments.
- At the last pixel of a frame: row wraps to 0 (implicit next frame).
- pix_sof with pix_vld forces the current pixel's position to (0,0); the following pixel is (0,1). This applies mid-frame too.
- Pixels in flight when sof arrives complete normally.

**Line stores and window**
- Two stores, L1 (previous row) and L2 (row before that), each addressed by col.
- Per accepted pixel, in the same cycle:
  - read L1[col] and L2[col];
  - write L2[col] ← old L1[col] and L1[col] ← pix_data (read-before-write).
- Window: 3 columns × 3 rows. On each accepted pixel, shift one column left and load the new column {L2[col], L1[col], pix_data}.
- Store contents are not reset. Rows 0–1 outputs are forced to 0, so stale data is never visible.

**Output value**
- Kernel [1 2 1; 2 4 2; 1 2 1]. Sum width DATA_WIDTH+4.
- out_data = (sum + 8) >> 4, i.e. round half up. It never exceeds 2^DATA_WIDTH-1, so no saturation is needed.
- The output for input position (r,c) is the blur of the window centred at (r-1, c-1).
- Output is forced to 0 when r < 2 or c < 2.
- Result: the output frame is the same size as the input, content shifted by (+1,+1), with a 2-pixel zero border on the top and left.

## Timing
- Latency is fixed at 2 cycles: a pixel sampled at edge N produces out_vld, out_data and flags that are valid after edge N+2.
- Flags travel with their pixel.
- Pipeline:
  - Stage 1 registers the window and position-derived flags.
  - Stage 2 registers the sum/round result.
- Gaps in pix_vld are allowed and produce matching gaps in out_vld. Back-to-back input gives back-to-back output.
- The window and counters advance only on pix_vld.
- Values on reset:
  - out_vld, out_sof, out_eol, out_eof and out_data are 0.
  - Counters are at (0,0) and window registers are 0.
- Reset asserted mid-frame:
  - Outputs clear immediately (asynchronous).
  - The in-flight pixels are discarded.
  - The first pixel after release is position (0,0) whether or not pix_sof is high.
- pix_sof without pix_vld is ignored.

## Test plan
Bench configuration for all scenarios: IMG_WIDTH=8, IMG_HEIGHT=6, DATA_WIDTH=8.
- **Constant frame:** all 100, continuous -> 48 outputs; rows 0–1 and cols 0–1 are 0, all others 100. out_sof on the 1st output, out_eol on every 8th, out_eof on the 48th. Each output lags its input by 2 cycles.
- **Impulse:** 255 at input (2,3), else 0 -> out(3,4)=64; out(2,4), (4,4), (3,3), (3,5) = 32; out(2,3), (2,5), (4,3), (4,5) = 16; all other outputs 0.
- **Full scale:** all 255 -> every interior output is 255 (no overflow).
- **Random gaps:** the same frame with pix_vld randomly deasserted -> the output values sequence is identical to the continuous run, and each out_vld comes exactly 2 cycles after its pix_vld.
- **sof mid-frame and reset:**
  - pix_sof asserted at input (3,5) -> that pixel is treated as (0,0); the next 2 rows of output are 0.
  - rst_n pulsed mid-frame -> outputs go 0 immediately; the next frame matches the constant-frame expected values.

Source files
------------

// File: rtl/canny_gauss3x3.sv
// canny_gauss3x3 - streaming 3x3 Gaussian smoothing stage (kernel 1 2 1 / 2 4 2 / 1 2 1).
//
// Stream handshake: valid-only. A pixel is accepted on every rising clk edge
// where pix_vld is high. There is no ready/backpressure. out_vld is high for
// exactly one cycle per accepted pixel, with the same spacing as the input.
// pix_sof, out_sof, out_eol and out_eof are meaningful only while their
// valid is high.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pix_vld         input pixel valid
//   pix_sof         start of frame; forces the current pixel to position (0,0)
//   pix_data        input grey pixel
//   out_vld         output pixel valid; follows the accepting edge by 2 edges
//   out_sof         output belongs to input position (0,0)
//   out_eol         output belongs to input column IMG_WIDTH-1
//   out_eof         output belongs to input (IMG_HEIGHT-1, IMG_WIDTH-1)
//   out_data        smoothed pixel, (sum + 8) >> 4
//
// Pipeline: the accepting edge N loads the window and position flags. Edge
// N+1 registers the kernel sum, with zero forced on the top and left 2-pixel
// border. Edge N+2 registers the rounded result onto the outputs.
module canny_gauss3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_vld,
  input  logic                  pix_sof,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  out_vld,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int SW = DATA_WIDTH + 4;

  // Position counters: col_q/row_q hold the position the next pixel gets
  // unless pix_sof overrides it.
  logic [CW-1:0] col_q, cur_col;
  logic [RW-1:0] row_q, cur_row;
  logic          last_col, last_row;

  always_comb begin
    cur_col  = pix_sof ? '0 : col_q;
    cur_row  = pix_sof ? '0 : row_q;
    last_col = (cur_col == CW'(IMG_WIDTH - 1));
    last_row = (cur_row == RW'(IMG_HEIGHT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pix_vld) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : cur_row + RW'(1);
      end else begin
        col_q <= cur_col + CW'(1);
        row_q <= cur_row;
      end
    end
  end

  // Line stores: l1 holds the previous row and l2 the row before it. They are
  // deliberately not reset, because rows 0-1 are forced to zero at the output.
  logic [DATA_WIDTH-1:0] l1_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] l2_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] l1_rd, l2_rd;

  assign l1_rd = l1_mem[cur_col];
  assign l2_rd = l2_mem[cur_col];

  // Read-before-write: the old l1 value moves down into l2 in the same cycle.
  always_ff @(posedge clk) begin
    if (pix_vld) begin
      l1_mem[cur_col] <= pix_data;
      l2_mem[cur_col] <= l1_rd;
    end
  end

  // win[k][j]: k = column (0 oldest, 2 newest), j = row (0 = r-2, 2 = r).
  logic [DATA_WIDTH-1:0] win [3][3];
  logic s1_vld, s1_sof, s1_eol, s1_eof, s1_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 3; j++) begin
          win[k][j] <= '0;
        end
      end
      s1_vld  <= 1'b0;
      s1_sof  <= 1'b0;
      s1_eol  <= 1'b0;
      s1_eof  <= 1'b0;
      s1_zero <= 1'b1;
    end else begin
      s1_vld <= pix_vld;
      s1_sof <= pix_vld && (cur_col == '0) && (cur_row == '0);
      s1_eol <= pix_vld && last_col;
      s1_eof <= pix_vld && last_col && last_row;
      if (pix_vld) begin
        win[0]    <= win[1];
        win[1]    <= win[2];
        win[2][0] <= l2_rd;
        win[2][1] <= l1_rd;
        win[2][2] <= pix_data;
        // The window centre is (r-1, c-1). It is only valid once two full
        // rows and two columns of this row have been seen.
        s1_zero   <= (cur_row < RW'(2)) || (cur_col < CW'(2));
      end
    end
  end

  logic [SW-1:0] win_sum;

  always_comb begin
    win_sum = SW'(win[0][0]) + SW'(win[0][2]) + SW'(win[2][0]) + SW'(win[2][2])
            + ((SW'(win[0][1]) + SW'(win[1][0]) + SW'(win[1][2]) + SW'(win[2][1])) << 1)
            + (SW'(win[1][1]) << 2);
  end

  logic          s2_vld, s2_sof, s2_eol, s2_eof;
  logic [SW-1:0] s2_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_sof <= 1'b0;
      s2_eol <= 1'b0;
      s2_eof <= 1'b0;
      s2_sum <= '0;
    end else begin
      s2_vld <= s1_vld;
      s2_sof <= s1_sof;
      s2_eol <= s1_eol;
      s2_eof <= s1_eof;
      s2_sum <= s1_zero ? '0 : win_sum;
    end
  end

  // Max sum is 16*(2^DW-1); adding 8 still fits SW bits, so there is no saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_sof  <= 1'b0;
      out_eol  <= 1'b0;
      out_eof  <= 1'b0;
      out_data <= '0;
    end else begin
      out_vld  <= s2_vld;
      out_sof  <= s2_sof;
      out_eol  <= s2_eol;
      out_eof  <= s2_eof;
      out_data <= DATA_WIDTH'((s2_sum + SW'(8)) >> 4);
    end
  end

endmodule

// File: tb/tb_canny_gauss3x3.sv
// tb_canny_gauss3x3 - directed bench for canny_gauss3x3 on an 8x6 image.
// Drivers push {issue edge, data, sof, eol, eof} into exp_q. A negedge
// monitor pops one entry per out_vld and checks the value, the flags and the
// 2-edge latency.
module tb_canny_gauss3x3;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int EW = 32 + DW + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_vld = 1'b0;
  logic          pix_sof = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic          out_vld, out_sof, out_eol, out_eof;
  logic [DW-1:0] out_data;

  canny_gauss3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_vld(pix_vld), .pix_sof(pix_sof), .pix_data(pix_data),
    .out_vld(out_vld), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .out_data(out_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference values (hand-derived) ----------------
  // kind 0: constant 100, kind 1: 255 impulse at (2,3), kind 2: all 255
  function automatic logic [DW-1:0] in_px(input int kind, input int r, input int c);
    if (kind == 0) return 8'd100;
    if (kind == 2) return 8'd255;
    return (r == 2 && c == 3) ? 8'd255 : 8'd0;
  endfunction

  function automatic logic [DW-1:0] exp_px(input int kind, input int r, input int c);
    int dr, dc;
    if (r < 2 || c < 2) return 8'd0;
    if (kind == 0) return 8'd100;
    if (kind == 2) return 8'd255;
    dr = (r > 3) ? r - 3 : 3 - r;
    dc = (c > 4) ? c - 4 : 4 - c;
    if (dr == 0 && dc == 0) return 8'd64;
    if (dr + dc == 1) return 8'd32;
    if (dr == 1 && dc == 1) return 8'd16;
    return 8'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_vld  = 1'b0;
      pix_sof  = 1'b0;
      pix_data = DW'($urandom_range(0, 255));
    end
  endtask

  task automatic drive_px(input logic [DW-1:0] d, input logic sof, input logic [DW-1:0] ed,
                          input int r, input int c);
    @(negedge clk);
    pix_vld  = 1'b1;
    pix_sof  = sof;
    pix_data = d;
    exp_q.push_back({32'(cyc + 1), ed, 1'(r == 0 && c == 0), 1'(c == W - 1),
                     1'(r == H - 1 && c == W - 1)});
  endtask

  // Drives the first n pixels of a frame of the given kind.
  task automatic send_pixels(input int kind, input int n, input bit sof_first, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      drive_px(in_px(kind, i / W, i % W), (i == 0) && sof_first,
               exp_px(kind, i / W, i % W), i / W, i % W);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && out_vld) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_vld", 32'(out_vld), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e[DW+2:3]));
        check("out_sof", 32'(out_sof), 32'(e[2]));
        check("out_eol", 32'(out_eol), 32'(e[1]));
        check("out_eof", 32'(out_eof), 32'(e[0]));
        check("latency", 32'(cyc) - e[EW-1 -: 32], 32'd2);
      end
    end
  end

  // ---------------- stimulus sequence ----------------
  initial begin
    #2;
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_sof", 32'(out_sof), 32'd0);
    check("rst_out_eol", 32'(out_eol), 32'd0);
    check("rst_out_eof", 32'(out_eof), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send_pixels(0, W * H, 1'b1, 1'b0);   // constant frame
    send_pixels(1, W * H, 1'b1, 1'b0);   // impulse
    send_pixels(2, W * H, 1'b1, 1'b0);   // full scale
    idle(4);
    send_pixels(1, W * H, 1'b1, 1'b1);   // impulse with random gaps
    idle(3);

    // sof at input (3,5): that pixel restarts the frame at (0,0)
    send_pixels(0, 3 * W + 5, 1'b1, 1'b0);
    send_pixels(0, W * H, 1'b1, 1'b0);
    idle(4);

    // reset in the middle of row 3 while outputs are non-zero
    send_pixels(0, 4 * W, 1'b1, 1'b0);
    #2;
    rst_n   = 1'b0;
    pix_vld = 1'b0;
    pix_sof = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_vld", 32'(out_vld), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_eol", 32'(out_eol), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_pixels(0, W * H, 1'b0, 1'b0);   // first pixel is (0,0) without pix_sof
    idle(6);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
